// File: rtl/sr_flop_bank.sv
// WIDTH-bit bank of clocked set/reset flops with selectable S=R=1 resolution,
// parallel load, rise pulses, change and conflict flags. Macro: SRBANK_CONFLICT_CNT_EN.
module sr_flop_bank #(
    parameter int                 WIDTH         = 8,
    parameter int                 CONFLICT_MODE = 0,
    parameter logic [WIDTH-1:0]   RESET_VAL     = {WIDTH{1'b0}},
    parameter int                 CNT_W         = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rise,
    output logic             changed,
    output logic             conflict,
    output logic [CNT_W-1:0] conflict_cnt
);

    // Illegal configurations stop elaboration rather than silently misbehave.
    if (CONFLICT_MODE < 0 || CONFLICT_MODE > 3) begin : g_bad_mode
        $error("sr_flop_bank: CONFLICT_MODE must be 0..3");
    end
    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
        $error("sr_flop_bank: WIDTH must be 1..64");
    end

    logic [WIDTH-1:0] q_next;
    logic             conflict_hit;

    // No handshake: enable is an active-low update qualifier, and every input
    // sampled on an edge is reflected in q on that same edge.
    always_comb begin
        q_next       = q;
        conflict_hit = 1'b0;
        if (!enable) begin
            if (load) begin
                q_next = load_data;
            end else begin
                conflict_hit = |(s & r);
                for (int i = 0; i < WIDTH; i++) begin
                    case ({s[i], r[i]})
                        2'b10: q_next[i] = 1'b1;
                        2'b01: q_next[i] = 1'b0;
                        2'b11: begin
                            if (CONFLICT_MODE == 0)      q_next[i] = 1'b0;
                            else if (CONFLICT_MODE == 1) q_next[i] = 1'b1;
                            else if (CONFLICT_MODE == 2) q_next[i] = ~q[i];
                            else                         q_next[i] = q[i];
                        end
                        default: q_next[i] = q[i];
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            q        <= RESET_VAL;
            rise     <= '0;
            changed  <= 1'b0;
            conflict <= 1'b0;
        end else begin
            q        <= q_next;
            rise     <= ~q & q_next;
            changed  <= |(q ^ q_next);
            conflict <= conflict | conflict_hit;
        end
    end

`ifdef SRBANK_CONFLICT_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Counts conflict cycles, not conflicting bits; sticks at all-ones.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (conflict_hit && cnt_q != {CNT_W{1'b1}}) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign conflict_cnt = cnt_q;
`else
    assign conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_sr_flop_bank.sv
// Directed bench for sr_flop_bank: four instances (one per conflict mode)
// share the same stimulus and are checked against hand-computed values.
module tb_sr_flop_bank;

    localparam int W = 8;
    localparam int CW = 2;
    localparam logic [W-1:0] RV = 8'hA5;

    logic          clock = 1'b0;
    logic          reset;
    logic          enable;
    logic [W-1:0]  s, r, load_data;
    logic          load;

    logic [W-1:0]  q_w    [4];
    logic [W-1:0]  rise_w [4];
    logic          chg_w  [4];
    logic          cfl_w  [4];
    logic [CW-1:0] cnt_w  [4];

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        sr_flop_bank #(
            .WIDTH(W), .CONFLICT_MODE(g), .RESET_VAL(RV), .CNT_W(CW)
        ) u_dut (
            .clock(clock), .reset(reset), .enable(enable), .s(s), .r(r),
            .load(load), .load_data(load_data), .q(q_w[g]), .rise(rise_w[g]),
            .changed(chg_w[g]), .conflict(cfl_w[g]), .conflict_cnt(cnt_w[g])
        );
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic rst, input logic en_n, input logic ld,
                         input logic [W-1:0] ld_d, input logic [W-1:0] sv,
                         input logic [W-1:0] rv);
        reset = rst; enable = en_n; load = ld; load_data = ld_d; s = sv; r = rv;
        step();
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 8'h00, 8'h00, 8'h00);
        for (int i = 0; i < 4; i++) begin
            checks++; if (q_w[i] !== RV) begin failures++; $display("FAIL reset_q m%0d got=%h exp=%h", i, q_w[i], RV); end
            checks++; if (rise_w[i] !== 8'h00) begin failures++; $display("FAIL reset_rise m%0d got=%h exp=00", i, rise_w[i]); end
            checks++; if (chg_w[i] !== 1'b0) begin failures++; $display("FAIL reset_changed m%0d got=%b exp=0", i, chg_w[i]); end
            checks++; if (cfl_w[i] !== 1'b0) begin failures++; $display("FAIL reset_conflict m%0d got=%b exp=0", i, cfl_w[i]); end
            checks++; if (cnt_w[i] !== 2'd0) begin failures++; $display("FAIL reset_cnt m%0d got=%0d exp=0", i, cnt_w[i]); end
        end
        drive(0, 0, 0, 8'h00, 8'h00, 8'h00);
        checks++; if (q_w[0] !== RV) begin failures++; $display("FAIL hold_after_reset_q got=%h exp=%h", q_w[0], RV); end
        checks++; if (chg_w[0] !== 1'b0) begin failures++; $display("FAIL hold_after_reset_changed got=%b exp=0", chg_w[0]); end
    endtask

    task automatic test_set_clear();
        drive(0, 0, 1, 8'h00, 8'h00, 8'h00);
        checks++; if (chg_w[0] !== 1'b1) begin failures++; $display("FAIL load00_changed got=%b exp=1", chg_w[0]); end
        drive(0, 0, 0, 8'h00, 8'h0F, 8'h00);
        checks++; if (q_w[1] !== 8'h0F) begin failures++; $display("FAIL set_q got=%h exp=0f", q_w[1]); end
        checks++; if (rise_w[1] !== 8'h0F) begin failures++; $display("FAIL set_rise got=%h exp=0f", rise_w[1]); end
        checks++; if (chg_w[1] !== 1'b1) begin failures++; $display("FAIL set_changed got=%b exp=1", chg_w[1]); end
        drive(0, 0, 0, 8'h00, 8'h00, 8'h03);
        checks++; if (q_w[2] !== 8'h0C) begin failures++; $display("FAIL clear_q got=%h exp=0c", q_w[2]); end
        checks++; if (rise_w[2] !== 8'h00) begin failures++; $display("FAIL clear_rise got=%h exp=00", rise_w[2]); end
        checks++; if (chg_w[2] !== 1'b1) begin failures++; $display("FAIL clear_changed got=%b exp=1", chg_w[2]); end
        checks++; if (cfl_w[2] !== 1'b0) begin failures++; $display("FAIL clear_conflict got=%b exp=0", cfl_w[2]); end
    endtask

    task automatic test_back_to_back();
        // Independent bits in one edge: 0C -> set F0, clear 0C -> F0.
        drive(0, 0, 0, 8'h00, 8'hF0, 8'h0C);
        checks++; if (q_w[3] !== 8'hF0) begin failures++; $display("FAIL mixed_q got=%h exp=f0", q_w[3]); end
        checks++; if (rise_w[3] !== 8'hF0) begin failures++; $display("FAIL mixed_rise got=%h exp=f0", rise_w[3]); end
        // Loading the value already held is not a change.
        drive(0, 0, 1, 8'hF0, 8'h00, 8'h00);
        checks++; if (chg_w[0] !== 1'b0) begin failures++; $display("FAIL load_same_changed got=%b exp=0", chg_w[0]); end
        checks++; if (q_w[0] !== 8'hF0) begin failures++; $display("FAIL load_same_q got=%h exp=f0", q_w[0]); end
    endtask

    task automatic test_conflict_modes();
        logic [W-1:0] exp_q [4];
        logic [W-1:0] exp_rise [4];
        logic         exp_chg [4];
        exp_q    = '{8'h00, 8'hFF, 8'h0F, 8'hF0};
        exp_rise = '{8'h00, 8'h0F, 8'h0F, 8'h00};
        exp_chg  = '{1'b1, 1'b1, 1'b1, 1'b0};
        drive(0, 0, 0, 8'h00, 8'hFF, 8'hFF);
        for (int i = 0; i < 4; i++) begin
            checks++; if (q_w[i] !== exp_q[i]) begin failures++; $display("FAIL mode_q m%0d got=%h exp=%h", i, q_w[i], exp_q[i]); end
            checks++; if (rise_w[i] !== exp_rise[i]) begin failures++; $display("FAIL mode_rise m%0d got=%h exp=%h", i, rise_w[i], exp_rise[i]); end
            checks++; if (chg_w[i] !== exp_chg[i]) begin failures++; $display("FAIL mode_changed m%0d got=%b exp=%b", i, chg_w[i], exp_chg[i]); end
            checks++; if (cfl_w[i] !== 1'b1) begin failures++; $display("FAIL mode_conflict m%0d got=%b exp=1", i, cfl_w[i]); end
        end
        // enable=1 holds everything even with load and set asserted.
        drive(0, 1, 1, 8'h55, 8'hFF, 8'h00);
        for (int i = 0; i < 4; i++) begin
            checks++; if (q_w[i] !== exp_q[i]) begin failures++; $display("FAIL hold_q m%0d got=%h exp=%h", i, q_w[i], exp_q[i]); end
            checks++; if (rise_w[i] !== 8'h00) begin failures++; $display("FAIL hold_rise m%0d got=%h exp=00", i, rise_w[i]); end
            checks++; if (chg_w[i] !== 1'b0) begin failures++; $display("FAIL hold_changed m%0d got=%b exp=0", i, chg_w[i]); end
            checks++; if (cfl_w[i] !== 1'b1) begin failures++; $display("FAIL hold_conflict m%0d got=%b exp=1", i, cfl_w[i]); end
        end
    endtask

    task automatic test_priority();
        drive(1, 0, 0, 8'h00, 8'h00, 8'h00);
        drive(0, 1, 0, 8'h00, 8'hFF, 8'hFF);
        checks++; if (cfl_w[0] !== 1'b0) begin failures++; $display("FAIL disabled_conflict got=%b exp=0", cfl_w[0]); end
        checks++; if (q_w[0] !== RV) begin failures++; $display("FAIL disabled_q got=%h exp=%h", q_w[0], RV); end
        drive(0, 0, 1, 8'h3C, 8'hFF, 8'hFF);
        for (int i = 0; i < 4; i++) begin
            checks++; if (q_w[i] !== 8'h3C) begin failures++; $display("FAIL load_prio_q m%0d got=%h exp=3c", i, q_w[i]); end
            checks++; if (cfl_w[i] !== 1'b0) begin failures++; $display("FAIL load_prio_conflict m%0d got=%b exp=0", i, cfl_w[i]); end
        end
    endtask

    task automatic test_counter();
        logic [CW-1:0] exp_cnt;
        drive(1, 0, 0, 8'h00, 8'h00, 8'h00);
        for (int n = 1; n <= 5; n++) begin
            drive(0, 0, 0, 8'h00, 8'hFF, 8'hFF);
`ifdef SRBANK_CONFLICT_CNT_EN
            exp_cnt = (n > 3) ? 2'd3 : CW'(n);
`else
            exp_cnt = 2'd0;
`endif
            checks++; if (cnt_w[0] !== exp_cnt) begin failures++; $display("FAIL cnt_burst n=%0d got=%0d exp=%0d", n, cnt_w[0], exp_cnt); end
            checks++; if (cfl_w[0] !== 1'b1) begin failures++; $display("FAIL cnt_conflict n=%0d got=%b exp=1", n, cfl_w[0]); end
        end
        drive(1, 0, 0, 8'h00, 8'h00, 8'h00);
        drive(0, 0, 0, 8'h00, 8'hFF, 8'hFF);
        drive(0, 0, 0, 8'h00, 8'hFF, 8'hFF);
        // Reset mid-burst wins over the conflicting s/r and load.
        drive(1, 0, 1, 8'h77, 8'hFF, 8'hFF);
        checks++; if (cnt_w[0] !== 2'd0) begin failures++; $display("FAIL midreset_cnt got=%0d exp=0", cnt_w[0]); end
        checks++; if (cfl_w[0] !== 1'b0) begin failures++; $display("FAIL midreset_conflict got=%b exp=0", cfl_w[0]); end
        checks++; if (q_w[0] !== RV) begin failures++; $display("FAIL midreset_q got=%h exp=%h", q_w[0], RV); end
        drive(0, 0, 0, 8'h00, 8'h00, 8'h00);
        checks++; if (q_w[0] !== RV) begin failures++; $display("FAIL postreset_q got=%h exp=%h", q_w[0], RV); end
        checks++; if (rise_w[0] !== 8'h00) begin failures++; $display("FAIL postreset_rise got=%h exp=00", rise_w[0]); end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; load = 1'b0; load_data = '0; s = '0; r = '0;
        @(negedge clock);
        test_reset();
        test_set_clear();
        test_back_to_back();
        test_conflict_modes();
        test_priority();
        test_counter();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sr_flop_bank.md
Name: sr_flop_bank

Overview:
- WIDTH-bit bank of clocked set/reset flip-flops; successor to the single-bit SR flop.
- Adds a parametrised S=R=1 resolution mode, parallel load, and per-bit rising-edge pulses.
- Adds a change indicator and a sticky conflict flag, with an optional saturating conflict counter.
- Used wherever control/status flag groups are set and cleared by independent event sources.

Parameters:
- WIDTH, 8, number of flops in the bank (1..64).
- CONFLICT_MODE, 0, per-bit action when s=r=1: 0 reset-dominant (q=0), 1 set-dominant (q=1), 2 toggle (JK), 3 hold.
- RESET_VAL, {WIDTH{1'b0}}, value loaded into q on reset.
- CNT_W, 8, conflict counter width (used only with SRBANK_CONFLICT_CNT_EN).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  active-low update enable: 0 = bank updates, 1 = bank holds (same polarity as existing SR flop).
- s  in  WIDTH  per-bit set request.
- r  in  WIDTH  per-bit reset request.
- load  in  1  parallel load strobe (qualified by enable=0).
- load_data  in  WIDTH  parallel load value.
- q  out  WIDTH  flop outputs.
- rise  out  WIDTH  per-bit one-cycle pulse; bit i is 1 when q[i] went 0->1 on this edge.
- changed  out  1  one-cycle pulse; 1 when any q bit changed on this edge.
- conflict  out  1  sticky; set when any bit saw s=r=1 while updating.
- conflict_cnt  out  CNT_W  saturating count of conflict cycles (macro-dependent).

Behaviour:
- All outputs are registered and update only on the rising edge of clock.
- Reset (sync, highest priority):
  - q <= RESET_VAL; rise <= 0; changed <= 0; conflict <= 0; conflict_cnt <= 0.
  - Reset asserted mid-sequence discards any s/r/load that cycle.
  - First non-reset edge compares against RESET_VAL.
- Priority when reset=0: enable=1 > load > s/r.
- enable=1: q_next = q; rise <= 0; changed <= 0; conflict and conflict_cnt unchanged.
- enable=0, load=1: q_next = load_data; s, r ignored; no conflict recorded.
- enable=0, load=0, per bit i:
  - s=0, r=0: hold.
  - s=1, r=0: 1.
  - s=0, r=1: 0.
  - s=1, r=1: per CONFLICT_MODE (0 -> 0, 1 -> 1, 2 -> ~q[i], 3 -> q[i]).
- Bits update independently in the same cycle.
- rise <= ~q & q_next; changed <= |(q ^ q_next). Both are evaluated in every non-reset cycle, so both are 0 when q holds.
- conflict <= conflict | (~enable & ~load & |(s & r)). Cleared only by reset.
- Zero latency from input to q: q reflects inputs sampled on the same edge. No handshake.
- Width rule: s, r and load_data must be exactly WIDTH bits. Other values of CONFLICT_MODE are illegal; elaboration fails via generate-time check.

Optional Feature:
- Macro SRBANK_CONFLICT_CNT_EN.
- Defined:
  - conflict_cnt increments by 1 on every cycle that sets the conflict condition (enable=0, load=0, any s&r bit), counting cycles not bits.
  - Saturates at 2^CNT_W-1; no wrap.
  - Reset clears it to 0.
- Not defined: conflict_cnt is tied to 0, no counter registers are built, and the conflict flag behaves identically.

Test Plan:
- Reset, WIDTH=8, RESET_VAL=8'hA5: reset=1 for 1 edge -> q=8'hA5, rise=0, changed=0, conflict=0; then s=r=0, enable=0 -> q holds 8'hA5, changed=0.
- From q=8'h00, enable=0, s=8'h0F, r=0 -> q=8'h0F, rise=8'h0F, changed=1; next edge s=0, r=8'h03 -> q=8'h0C, rise=0, changed=1.
- Conflict modes, q=8'hF0, s=r=8'hFF, one edge:
  - mode 0 -> q=8'h00.
  - mode 1 -> q=8'hFF.
  - mode 2 -> q=8'h0F, rise=8'h0F.
  - mode 3 -> q=8'hF0, changed=0.
  - conflict=1 in all four modes.
- Hold/priority:
  - enable=1, s=8'hFF, load=1 -> q unchanged, rise=0, conflict unchanged.
  - enable=0, load=1, load_data=8'h3C, s=r=8'hFF -> q=8'h3C, conflict stays 0.
- Counter (macro defined, CNT_W=2): 5 consecutive conflict cycles -> conflict_cnt 1,2,3,3,3; reset mid-burst -> conflict_cnt=0, conflict=0, q=RESET_VAL next edge.
- Macro undefined: same stimulus as previous -> conflict_cnt stays 0, conflict=1.
